// File: rtl/instr_sequencer.sv
// instr_sequencer: program sequencer for the 16-bit ALU/register-file datapath.
// A small instruction buffer is filled through the load port. A start request
// replays the buffer to the datapath over valid/ready, for one or more passes,
// and can stop early when the datapath reports a zero result.
module instr_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int IW    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load_en,
  input  logic [AW-1:0] i_load_addr,
  input  logic [IW-1:0] i_load_data,
  input  logic [AW:0]   i_prog_len,
  input  logic [3:0]    i_loop_count,
  input  logic          i_halt_on_zero,
  input  logic          i_start,
  output logic          o_issue_valid,
  output logic [IW-1:0] o_issue_inst,
  input  logic          i_issue_ready,
  input  logic          i_zero_in,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_halted,
  output logic          o_load_err,
  output logic [AW-1:0] o_pc,
  output logic [7:0]    o_issue_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_next_state;

  logic [IW-1:0] r_buf [DEPTH];
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_len;
  logic [3:0]    r_passes;
  logic          r_hoz;
  logic [7:0]    r_issue_count;
  logic          r_halted;
  logic          r_load_err;

  logic [AW:0]   w_len_clamped;
  logic          w_fire;
  logic          w_last;
  logic          w_halt_hit;

  // Program length requests beyond the buffer size are treated as a full buffer
  always_comb begin
    w_len_clamped = i_prog_len;
    if (i_prog_len > DEPTH_L) begin
      w_len_clamped = DEPTH_L;
    end
  end

  // Handshake and end-of-pass decode, all from registered state plus ready/zero
  assign w_fire     = (r_state == S_RUN) && i_issue_ready;
  assign w_last     = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));
  assign w_halt_hit = r_hoz && i_zero_in;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: an empty program skips straight to the one-cycle finish
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = (w_len_clamped != '0) ? S_RUN : S_FINISH;
        end
      end
      S_RUN: begin
        if (w_fire && (w_halt_hit || (w_last && (r_passes == 4'd0)))) begin
          w_next_state = S_FINISH;
        end
      end
      S_FINISH: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only, so ready/zero never reach valid/inst
  always_comb begin
    o_busy        = 1'b0;
    o_issue_valid = 1'b0;
    o_done        = 1'b0;
    o_issue_inst  = '0;
    case (r_state)
      S_RUN: begin
        o_busy        = 1'b1;
        o_issue_valid = 1'b1;
        o_issue_inst  = r_buf[r_pc];
      end
      S_FINISH: begin
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  // Instruction buffer: writable whenever no run is using it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (i_load_en && (r_state != S_RUN)) begin
      r_buf[i_load_addr] <= i_load_data;
    end
  end

  // Run bookkeeping: captured settings, pc walk, pass count, status flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc          <= '0;
      r_len         <= '0;
      r_passes      <= '0;
      r_hoz         <= 1'b0;
      r_issue_count <= '0;
      r_halted      <= 1'b0;
      r_load_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_halted   <= 1'b0;
            r_load_err <= 1'b0;
            if (w_len_clamped != '0) begin
              r_len         <= w_len_clamped;
              r_passes      <= i_loop_count;
              r_hoz         <= i_halt_on_zero;
              r_pc          <= '0;
              r_issue_count <= '0;
            end
          end
        end
        S_RUN: begin
          if (i_load_en) begin
            r_load_err <= 1'b1;
          end
          if (w_fire) begin
            if (r_issue_count != 8'hFF) begin
              r_issue_count <= r_issue_count + 8'd1;
            end
            if (w_halt_hit) begin
              r_halted <= 1'b1;
            end else if (w_last) begin
              if (r_passes != 4'd0) begin
                r_pc     <= '0;
                r_passes <= r_passes - 4'd1;
              end
            end else begin
              r_pc <= r_pc + AW'(1);
            end
          end
        end
        default: begin
          r_pc <= r_pc;
        end
      endcase
    end
  end

  assign o_pc          = r_pc;
  assign o_issue_count = r_issue_count;
  assign o_halted      = r_halted;
  assign o_load_err    = r_load_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed self-checking bench for instr_sequencer.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        loadEn;
  logic [2:0]  loadAddr;
  logic [15:0] loadData;
  logic [3:0]  progLen;
  logic [3:0]  loopCount;
  logic        haltOnZero;
  logic        start;
  logic        issueValid;
  logic [15:0] issueInst;
  logic        issueReady;
  logic        zeroIn;
  logic        busy;
  logic        done;
  logic        halted;
  logic        loadErr;
  logic [2:0]  pc;
  logic [7:0]  issueCount;

  int testsRun    = 0;
  int testsFailed = 0;
  int busyCycles;

  logic [15:0] prog [3];

  instr_sequencer #(.DEPTH(8), .AW(3), .IW(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_load_en      (loadEn),
    .i_load_addr    (loadAddr),
    .i_load_data    (loadData),
    .i_prog_len     (progLen),
    .i_loop_count   (loopCount),
    .i_halt_on_zero (haltOnZero),
    .i_start        (start),
    .o_issue_valid  (issueValid),
    .o_issue_inst   (issueInst),
    .i_issue_ready  (issueReady),
    .i_zero_in      (zeroIn),
    .o_busy         (busy),
    .o_done         (done),
    .o_halted       (halted),
    .o_load_err     (loadErr),
    .o_pc           (pc),
    .o_issue_count  (issueCount)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the given number of cycles, leaving us 1 ns past the last edge
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Write one buffer slot through the load port
  task automatic loadSlot(input logic [2:0] addr, input logic [15:0] data);
    loadEn   = 1'b1;
    loadAddr = addr;
    loadData = data;
    applyStimulus(1);
    loadEn   = 1'b0;
  endtask

  // Pulse start for one cycle with the given run settings
  task automatic startRun(input logic [3:0] len, input logic [3:0] loops, input logic hoz);
    progLen    = len;
    loopCount  = loops;
    haltOnZero = hoz;
    start      = 1'b1;
    applyStimulus(1);
    start      = 1'b0;
  endtask

  // Directed test sequence
  initial begin
    prog[0] = 16'h6033;
    prog[1] = 16'h2433;
    prog[2] = 16'h0000;

    rst        = 1'b1;
    loadEn     = 1'b0;
    loadAddr   = '0;
    loadData   = '0;
    progLen    = '0;
    loopCount  = '0;
    haltOnZero = 1'b0;
    start      = 1'b0;
    issueReady = 1'b0;
    zeroIn     = 1'b0;

    // Reset state
    applyStimulus(2);
    checkOutput("rst_valid", issueValid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_inst", issueInst, 16'h0000);
    checkOutput("rst_pc", pc, 3'd0);
    checkOutput("rst_count", issueCount, 8'd0);
    rst = 1'b0;
    applyStimulus(1);

    // Single pass, datapath always ready
    for (int i = 0; i < 3; i++) loadSlot(3'(i), prog[i]);
    issueReady = 1'b1;
    startRun(4'd3, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("p1_valid", issueValid, 1'b1);
      checkOutput("p1_inst", issueInst, prog[i]);
      checkOutput("p1_done", done, 1'b0);
      applyStimulus(1);
    end
    checkOutput("p1_done_pulse", done, 1'b1);
    checkOutput("p1_valid_off", issueValid, 1'b0);
    checkOutput("p1_count", issueCount, 8'd3);
    checkOutput("p1_halted", halted, 1'b0);
    applyStimulus(1);
    checkOutput("p1_done_end", done, 1'b0);

    // Three passes of the same program
    startRun(4'd3, 4'd2, 1'b0);
    for (int i = 0; i < 9; i++) begin
      checkOutput("loop_pc", pc, 3'(i % 3));
      checkOutput("loop_inst", issueInst, prog[i % 3]);
      checkOutput("loop_done", done, 1'b0);
      applyStimulus(1);
    end
    checkOutput("loop_done_pulse", done, 1'b1);
    checkOutput("loop_count", issueCount, 8'd9);
    applyStimulus(1);
    checkOutput("loop_done_end", done, 1'b0);

    // Backpressure: ready only on every third cycle
    issueReady = 1'b0;
    busyCycles = 0;
    startRun(4'd3, 4'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) begin
        issueReady = (c == 2);
        if (busy) busyCycles++;
        checkOutput("bp_pc", pc, 3'(k));
        checkOutput("bp_inst", issueInst, prog[k]);
        applyStimulus(1);
      end
    end
    issueReady = 1'b0;
    checkOutput("bp_done_pulse", done, 1'b1);
    checkOutput("bp_busy_cycles", busyCycles, 9);
    checkOutput("bp_count", issueCount, 8'd3);
    applyStimulus(1);

    // Early halt on the second accepted instruction
    issueReady = 1'b1;
    startRun(4'd3, 4'd0, 1'b1);
    checkOutput("hz_inst0", issueInst, prog[0]);
    applyStimulus(1);
    zeroIn = 1'b1;
    checkOutput("hz_inst1", issueInst, prog[1]);
    applyStimulus(1);
    zeroIn = 1'b0;
    checkOutput("hz_done_pulse", done, 1'b1);
    checkOutput("hz_valid_off", issueValid, 1'b0);
    checkOutput("hz_count", issueCount, 8'd2);
    checkOutput("hz_halted", halted, 1'b1);
    checkOutput("hz_pc", pc, 3'd1);
    applyStimulus(1);
    checkOutput("hz_halted_held", halted, 1'b1);

    // Empty program: straight to finish, halted cleared
    startRun(4'd0, 4'd0, 1'b0);
    checkOutput("empty_done", done, 1'b1);
    checkOutput("empty_valid", issueValid, 1'b0);
    checkOutput("empty_halted", halted, 1'b0);
    applyStimulus(1);
    checkOutput("empty_done_end", done, 1'b0);

    // Load during a run is refused and flagged
    issueReady = 1'b0;
    startRun(4'd3, 4'd0, 1'b0);
    loadEn   = 1'b1;
    loadAddr = 3'd0;
    loadData = 16'hBEEF;
    applyStimulus(1);
    loadEn   = 1'b0;
    checkOutput("le_flag", loadErr, 1'b1);
    issueReady = 1'b1;
    applyStimulus(3);
    checkOutput("le_done", done, 1'b1);
    applyStimulus(1);
    checkOutput("le_flag_held", loadErr, 1'b1);
    startRun(4'd1, 4'd0, 1'b0);
    checkOutput("le_flag_clear", loadErr, 1'b0);
    checkOutput("le_slot0_kept", issueInst, 16'h6033);
    applyStimulus(2);

    // Asynchronous reset in the middle of the second instruction
    issueReady = 1'b0;
    startRun(4'd3, 4'd0, 1'b0);
    issueReady = 1'b1;
    applyStimulus(1);
    issueReady = 1'b0;
    checkOutput("ar_pc_before", pc, 3'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_valid", issueValid, 1'b0);
    checkOutput("ar_busy", busy, 1'b0);
    checkOutput("ar_done", done, 1'b0);
    checkOutput("ar_pc", pc, 3'd0);
    applyStimulus(1);
    checkOutput("ar_done_held", done, 1'b0);
    rst = 1'b0;
    applyStimulus(1);
    startRun(4'd1, 4'd0, 1'b0);
    checkOutput("ar_slot0_valid", issueValid, 1'b1);
    checkOutput("ar_slot0_zero", issueInst, 16'h0000);
    issueReady = 1'b1;
    applyStimulus(1);
    checkOutput("ar_rerun_done", done, 1'b1);
    checkOutput("ar_rerun_count", issueCount, 8'd1);
    applyStimulus(1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
